// File: rtl/fpmul64_arbiter.sv
// Round-robin front end that shares one pipelined FP64 multiplier among NREQ requesters.
// The requester id and tag travel in a shadow pipe and come back with the FP64X result.
module fpmul64_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = 4,
  parameter int LAT  = 15,
  localparam int IDW  = $clog2(NREQ),
  localparam int CNTW = $clog2(LAT + 3)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*64-1:0]   req_a,
  input  logic [NREQ*64-1:0]   req_b,
  input  logic [NREQ*TAGW-1:0] req_tag,
  output logic [NREQ-1:0]      req_ready,
  output logic                 mul_ce,
  output logic [63:0]          mul_a,
  output logic [63:0]          mul_b,
  input  logic [117:0]         mul_o,
  input  logic [3:0]           mul_flags,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [TAGW-1:0]      rsp_tag,
  output logic [117:0]         rsp_o,
  output logic [3:0]           rsp_flags,
  output logic                 busy,
  output logic [CNTW-1:0]      inflight
);

  localparam int PW = IDW + 1;

  logic [NREQ-1:0][63:0]   req_a_arr;
  logic [NREQ-1:0][63:0]   req_b_arr;
  logic [NREQ-1:0][TAGW-1:0] req_tag_arr;

  assign req_a_arr   = req_a;
  assign req_b_arr   = req_b;
  assign req_tag_arr = req_tag;

  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  cand_idx;
  logic [PW-1:0]   cand;
  logic            grant_found;
  logic            accept;

  logic [63:0]     mul_a_q, mul_a_d;
  logic [63:0]     mul_b_q, mul_b_d;
  logic            issue_valid_q, issue_valid_d;
  logic [IDW-1:0]  issue_id_q, issue_id_d;
  logic [TAGW-1:0] issue_tag_q, issue_tag_d;

  logic [LAT-1:0]  pipe_valid_q, pipe_valid_d;
  logic [IDW-1:0]  pipe_id_q  [LAT];
  logic [IDW-1:0]  pipe_id_d  [LAT];
  logic [TAGW-1:0] pipe_tag_q [LAT];
  logic [TAGW-1:0] pipe_tag_d [LAT];

  logic            rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]  rsp_id_q, rsp_id_d;
  logic [TAGW-1:0] rsp_tag_q, rsp_tag_d;
  logic [117:0]    rsp_o_q, rsp_o_d;
  logic [3:0]      rsp_flags_q, rsp_flags_d;
  logic [CNTW-1:0] inflight_q, inflight_d;

  // Search upward from rr_ptr with wrap; cand is one bit wider so the wrap test cannot overflow.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    cand_idx    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, rr_ptr_q} + PW'(off);
      if (cand >= PW'(NREQ)) begin
        cand = cand - PW'(NREQ);
      end
      cand_idx = cand[IDW-1:0];
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign accept = grant_found && !stall && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end

    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    issue_valid_d = issue_valid_q;
    issue_id_d    = issue_id_q;
    issue_tag_d   = issue_tag_q;
    if (!stall) begin
      mul_a_d       = req_a_arr[grant_idx];
      mul_b_d       = req_b_arr[grant_idx];
      issue_valid_d = accept;
      issue_id_d    = grant_idx;
      issue_tag_d   = req_tag_arr[grant_idx];
    end
  end

  // Shadow pipe advances only with mul_ce so entry LAT-1 always matches mul_o.
  always_comb begin
    pipe_valid_d = pipe_valid_q;
    for (int k = 0; k < LAT; k++) begin
      pipe_id_d[k]  = pipe_id_q[k];
      pipe_tag_d[k] = pipe_tag_q[k];
    end
    if (!stall) begin
      pipe_valid_d  = {pipe_valid_q[LAT-2:0], issue_valid_q};
      pipe_id_d[0]  = issue_id_q;
      pipe_tag_d[0] = issue_tag_q;
      for (int k = 1; k < LAT; k++) begin
        pipe_id_d[k]  = pipe_id_q[k-1];
        pipe_tag_d[k] = pipe_tag_q[k-1];
      end
    end
  end

  always_comb begin
    rsp_valid_d = !stall && pipe_valid_q[LAT-1];
    rsp_id_d    = rsp_id_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_o_d     = rsp_o_q;
    rsp_flags_d = rsp_flags_q;
    if (!stall) begin
      rsp_id_d    = pipe_id_q[LAT-1];
      rsp_tag_d   = pipe_tag_q[LAT-1];
      rsp_o_d     = mul_o;
      rsp_flags_d = mul_flags;
    end

    inflight_d = inflight_q;
    if (accept && !rsp_valid_d) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!accept && rsp_valid_d) begin
      inflight_d = inflight_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q      <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_id_q    <= '0;
      issue_tag_q   <= '0;
      pipe_valid_q  <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= '0;
      rsp_tag_q     <= '0;
      rsp_o_q       <= '0;
      rsp_flags_q   <= '0;
      inflight_q    <= '0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      issue_valid_q <= issue_valid_d;
      issue_id_q    <= issue_id_d;
      issue_tag_q   <= issue_tag_d;
      pipe_valid_q  <= pipe_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_id_q      <= rsp_id_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_o_q       <= rsp_o_d;
      rsp_flags_q   <= rsp_flags_d;
      inflight_q    <= inflight_d;
    end
  end

  // Id/tag payload needs no reset: it is ignored wherever its valid bit is clear.
  always_ff @(posedge clk) begin
    pipe_id_q  <= pipe_id_d;
    pipe_tag_q <= pipe_tag_d;
  end

  assign mul_ce    = !stall;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_tag   = rsp_tag_q;
  assign rsp_o     = rsp_o_q;
  assign rsp_flags = rsp_flags_q;
  assign inflight  = inflight_q;
  assign busy      = (inflight_q != '0);

endmodule
